bcd_uart_reporter: RTL and testbench

Downstream consumer of the frequency meter's 8-digit BCD count. On each gate-time latch strobe it snapshots the 32-bit BCD result and transmits it as an ASCII line over a UART TX pin (8N1, LSB first). This gives a host-readable reading alongside the multiplexed 7-segment display. It runs on the same single clock as the timebase and counter logic.

---
 rtl/bcd_uart_reporter_if.sv | 21 ++
 rtl/bcd_uart_reporter.sv | 127 ++++++++++++
 tb/tb_bcd_uart_reporter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_uart_reporter_if.sv
// Signal bundle between the frequency meter's count latch and the UART line reporter.
// latch is a one-cycle strobe with no back-pressure; busy/overrun report whether it was taken.
interface bcd_uart_reporter_if;
  logic [31:0] bcd_in;
  logic        latch;
  logic        blank_lz;
  logic        tx;
  logic        busy;
  logic        overrun;
  logic [1:0]  dbg_state;

  modport master (
    output bcd_in, latch, blank_lz,
    input  tx, busy, overrun, dbg_state
  );

  modport slave (
    input  bcd_in, latch, blank_lz,
    output tx, busy, overrun, dbg_state
  );
endinterface

// File: rtl/bcd_uart_reporter.sv
// Snapshots an 8-digit BCD count on latch and sends it as "DDDDDDDD\r\n" over an 8N1 UART.
// Leading zeros may be sent as spaces; digits A-F are sent as '?'.
module bcd_uart_reporter #(
  parameter int BAUD_DIV = 434
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_uart_reporter_if.slave bus
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_MAX = CW'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic [3:0]    r_char;
  logic [7:0]    r_shift;
  logic [31:0]   r_shadow;
  logic          r_blank;
  logic          r_tx;
  logic          r_busy;
  logic          r_overrun;

  logic          w_tick;
  logic [7:0]    w_first_byte;
  logic [7:0]    w_next_byte;

  // ASCII for character idx of the line; a digit stays blanked only while
  // it and every more-significant digit are zero, and the last digit never is.
  function automatic logic [7:0] char_byte(input logic [31:0] bcd,
                                           input logic        blank,
                                           input logic [3:0]  idx);
    logic [7:0] res;
    logic [3:0] d;
    logic       lead;
    res  = (idx == 4'd8) ? 8'h0D : 8'h0A;
    lead = blank;
    for (int k = 0; k < 8; k++) begin
      d    = bcd[(7 - k) * 4 +: 4];
      lead = lead && (d == 4'd0) && (k != 7);
      if (4'(k) == idx) begin
        if (lead)           res = 8'h20;
        else if (d > 4'd9)  res = 8'h3F;
        else                res = {4'h3, d};
      end
    end
    return res;
  endfunction

  assign w_tick       = (r_baud == BAUD_MAX);
  assign w_first_byte = char_byte(bus.bcd_in, bus.blank_lz, 4'd0);
  assign w_next_byte  = char_byte(r_shadow, r_blank, r_char + 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit     <= '0;
      r_char    <= '0;
      r_shift   <= '0;
      r_shadow  <= '0;
      r_blank   <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.latch) begin
        r_shadow  <= bus.bcd_in;
        r_blank   <= bus.blank_lz;
        r_shift   <= w_first_byte;
        r_char    <= '0;
        r_baud    <= '0;
        r_tx      <= 1'b0;
        r_busy    <= 1'b1;
        r_overrun <= 1'b0;
        r_state   <= S_START;
      end
    end else begin
      if (bus.latch) r_overrun <= 1'b1;
      r_baud <= w_tick ? '0 : r_baud + 1'b1;
      if (w_tick) begin
        case (r_state)
          S_START: begin
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
            r_bit   <= '0;
            r_state <= S_DATA;
          end
          S_DATA: begin
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
              r_bit   <= r_bit + 3'd1;
            end
          end
          default: begin
            // Stop bit finished: either chain straight into the next start bit or go idle.
            if (r_char == 4'd9) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_char  <= r_char + 4'd1;
              r_shift <= w_next_byte;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end
          end
        endcase
      end
    end
  end

  assign bus.tx        = r_tx;
  assign bus.busy      = r_busy;
  assign bus.overrun   = r_overrun;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_bcd_uart_reporter.sv
// Directed and randomized check of bcd_uart_reporter: every tx cycle is compared with
// the waveform expected from the line text, and mid-bit decoded bytes go through exp_q.
module tb_bcd_uart_reporter;

  localparam int B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bcd_uart_reporter_if bus();

  bcd_uart_reporter #(.BAUD_DIV(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference line: text built digit by digit from the count, most significant first.
  function automatic void model_line(input logic [31:0] v, input logic bl);
    logic       lead;
    logic [3:0] d;
    exp_q.delete();
    lead = bl;
    for (int i = 0; i < 8; i++) begin
      d = v[31 - 4 * i -: 4];
      if (lead && d == 4'd0 && i < 7) begin
        exp_q.push_back(8'h20);
      end else begin
        lead = 1'b0;
        exp_q.push_back((d < 4'd10) ? (8'h30 + 8'(d)) : 8'h3F);
      end
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // Called just after a rising edge; leaves just after the edge following the latch cycle.
  task automatic start_line(input logic [31:0] v, input logic bl, input logic exp_ovr);
    bus.bcd_in   = v;
    bus.blank_lz = bl;
    bus.latch    = 1'b1;
    @(negedge clk);
    chk("busy_in_latch_cycle", bus.busy, 0);
    chk("overrun_in_latch_cycle", bus.overrun, exp_ovr);
    @(posedge clk); #1;
    bus.latch    = 1'b0;
    bus.bcd_in   = $urandom;
    bus.blank_lz = 1'($urandom_range(0, 1));
    model_line(v, bl);
  endtask

  // Walks the 100*B frame cycles; optional stray latch at inj_cyc, optional reset at rst_cyc.
  task automatic check_frame(input int inj_cyc, input logic [31:0] inj_val, input int rst_cyc);
    logic [7:0] line [10];
    logic [7:0] rx;
    logic       ebit;
    int         ch;
    int         pos;
    for (int i = 0; i < 10; i++) line[i] = exp_q[i];
    rx = '0;
    for (int c = 0; c < 100 * B; c++) begin
      bus.latch = (c == inj_cyc);
      if (c == inj_cyc) bus.bcd_in = inj_val;
      if (c == rst_cyc) begin
        #2 rst_n = 1'b0;
        #1;
        chk("tx_async_reset", bus.tx, 1);
        chk("busy_async_reset", bus.busy, 0);
        chk("overrun_async_reset", bus.overrun, 0);
        bus.latch = 1'b0;
        exp_q.delete();
        return;
      end
      @(negedge clk);
      ch  = c / (10 * B);
      pos = (c % (10 * B)) / B;
      if (pos == 0)      ebit = 1'b0;
      else if (pos == 9) ebit = 1'b1;
      else               ebit = line[ch][pos - 1];
      chk("tx_bit", bus.tx, ebit);
      chk("busy_in_frame", bus.busy, 1);
      chk("overrun_in_frame", bus.overrun, (inj_cyc >= 0 && c > inj_cyc));
      if (c % B == B / 2) begin
        if (pos >= 1 && pos <= 8) rx[pos - 1] = bus.tx;
        if (pos == 9) chk("rx_byte", rx, exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    bus.latch = 1'b0;
    chk("all_bytes_seen", exp_q.size(), 0);
  endtask

  task automatic idle_check(input int n, input logic exp_ovr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("tx_idle", bus.tx, 1);
      chk("busy_idle", bus.busy, 0);
      chk("overrun_idle", bus.overrun, exp_ovr);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [31:0] v;
    logic        bl;
    bus.bcd_in   = '0;
    bus.latch    = 1'b0;
    bus.blank_lz = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_tx", bus.tx, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_overrun", bus.overrun, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_check(2, 0);

    // Blanked value, busy for exactly 100*B cycles
    start_line(32'h0001_2345, 1'b1, 1'b0);
    check_frame(-1, '0, -1);
    idle_check(2, 0);

    // Zero in both blanking modes
    start_line(32'h0000_0000, 1'b0, 1'b0);
    check_frame(-1, '0, -1);
    idle_check(1, 0);
    start_line(32'h0000_0000, 1'b1, 1'b0);
    check_frame(-1, '0, -1);
    idle_check(1, 0);

    // Invalid digits end blanking
    start_line(32'h0AB0_0009, 1'b1, 1'b0);
    check_frame(-1, '0, -1);
    idle_check(1, 0);

    // Overrun, then a back-to-back latch in the cycle busy falls clears it
    start_line(32'h1111_1111, 1'b0, 1'b0);
    check_frame(50, 32'h2222_2222, -1);
    start_line(32'h3333_3333, 1'b0, 1'b1);
    check_frame(-1, '0, -1);
    idle_check(3, 0);

    // Reset mid-frame with overrun already set
    start_line(32'h9876_5432, 1'b1, 1'b0);
    check_frame(20, 32'h5555_5555, 150);
    repeat (3) begin
      @(posedge clk); #1;
      chk("tx_held_in_reset", bus.tx, 1);
      chk("busy_held_in_reset", bus.busy, 0);
    end
    rst_n = 1'b1;
    idle_check(2, 0);
    start_line(32'h0040_0700, 1'b1, 1'b0);
    check_frame(-1, '0, -1);
    idle_check(1, 0);

    // Random counts, biased towards zeros so blanking runs vary
    repeat (4) begin
      for (int d = 0; d < 8; d++)
        v[4 * d +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bl = 1'($urandom_range(0, 1));
      start_line(v, bl, 1'b0);
      check_frame(-1, '0, -1);
      idle_check($urandom_range(0, 3), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
